// File: rtl/fp_compare_pipe_if.sv
// fp_compare_pipe_if: issue/writeback bundle for the DLFloat compare unit.
//
// Handshake contract:
//   - An operation transfers on the rising edge where in_valid && in_ready.
//   - A result transfers on the rising edge where out_valid && out_ready.
//   - A producer holding valid must keep its payload stable until the
//     transfer happens.
//
// Signals:
//   in_valid/in_ready  : operation handshake
//   opcode             : 000 LT, 001 GT, 010 EQ, 011 LE, 100 GE, 101 NE, 110 MIN, 111 MAX
//   a, b               : packed operands, lane i at [i*W +: W]
//   out_valid/out_ready: result handshake
//   result             : packed per-lane result
//
// Modports:
//   master : the issuing side (drives operands, consumes results)
//   slave  : the compare unit
interface fp_compare_pipe_if #(
    parameter int LANES = 1,
    parameter int W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           opcode;
    logic [LANES*W-1:0]   a;
    logic [LANES*W-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   result;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: multi-lane DLFloat compare / MIN / MAX unit, two-stage
// valid/ready pipeline with a sticky invalid (NaN) flag.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : fp_compare_pipe_if.slave (operands, opcode, result handshake)
//   flag_nv  : sticky flag, set when an operation with a NaN operand in any
//              lane enters the output stage
//   flag_clr : synchronous clear of flag_nv (a simultaneous set wins)
//
// Format: sign, EXP_W exponent bits, MAN_W mantissa bits. NaN has exponent
// and mantissa all ones; zero has both fields zero; no subnormals. The
// interface instance must be sized with W = 1 + EXP_W + MAN_W.
module fp_compare_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_compare_pipe_if.slave    bus,
    output logic                flag_nv,
    input  logic                flag_clr
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [2:0] {
        OP_LT  = 3'b000,
        OP_GT  = 3'b001,
        OP_EQ  = 3'b010,
        OP_LE  = 3'b011,
        OP_GE  = 3'b100,
        OP_NE  = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } op_e;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {(W-1){1'b1}}};

    // One global advance for both stages: everything moves or everything holds.
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- stage 1: lane decode ----------------
    logic [LANES-1:0] d_a_nan, d_b_nan, d_a_zero, d_b_zero, d_mag_lt, d_mag_eq;

    always_comb begin
        d_a_nan  = '0;
        d_b_nan  = '0;
        d_a_zero = '0;
        d_b_zero = '0;
        d_mag_lt = '0;
        d_mag_eq = '0;
        for (int i = 0; i < LANES; i++) begin
            // {exp,man} is the magnitude; NaN is the all-ones magnitude.
            d_a_nan[i]  = &bus.a[i*W +: W-1];
            d_b_nan[i]  = &bus.b[i*W +: W-1];
            d_a_zero[i] = ~|bus.a[i*W +: W-1];
            d_b_zero[i] = ~|bus.b[i*W +: W-1];
            d_mag_lt[i] = bus.a[i*W +: W-1] <  bus.b[i*W +: W-1];
            d_mag_eq[i] = bus.a[i*W +: W-1] == bus.b[i*W +: W-1];
        end
    end

    logic               s1_valid;
    op_e                s1_op;
    logic [LANES*W-1:0] s1_a, s1_b;
    logic [LANES-1:0]   s1_a_nan, s1_b_nan, s1_a_zero, s1_b_zero, s1_mag_lt, s1_mag_eq;

    // ---------------- stage 2: final select ----------------
    logic [LANES*W-1:0] nxt_result;
    logic               nxt_nan;
    logic [W-1:0]       la, lb, lane;
    logic               lt, eq, zz, nan_l, sa, sb;

    always_comb begin
        nxt_result = '0;
        nxt_nan    = 1'b0;
        la         = '0;
        lb         = '0;
        lane       = '0;
        lt         = 1'b0;
        eq         = 1'b0;
        zz         = 1'b0;
        nan_l      = 1'b0;
        sa         = 1'b0;
        sb         = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            la    = s1_a[i*W +: W];
            lb    = s1_b[i*W +: W];
            sa    = la[W-1];
            sb    = lb[W-1];
            nan_l = s1_a_nan[i] | s1_b_nan[i];
            zz    = s1_a_zero[i] & s1_b_zero[i];

            // a < b ignoring NaN; +0/-0 are equal, negatives reverse magnitude.
            if (zz)
                lt = 1'b0;
            else if (sa != sb)
                lt = sa;
            else if (!sa)
                lt = s1_mag_lt[i];
            else
                lt = !s1_mag_lt[i] && !s1_mag_eq[i];
            eq = zz || ((sa == sb) && s1_mag_eq[i]);

            case (s1_op)
                OP_LT:   lane = {W{!nan_l && lt}};
                OP_GT:   lane = {W{!nan_l && !lt && !eq}};
                OP_EQ:   lane = {W{!nan_l && eq}};
                OP_LE:   lane = {W{!nan_l && (lt || eq)}};
                OP_GE:   lane = {W{!nan_l && !lt}};
                OP_NE:   lane = {W{nan_l || !eq}};
                OP_MIN: begin
                    if (s1_a_nan[i] && s1_b_nan[i]) lane = CANON_NAN;
                    else if (s1_a_nan[i])           lane = lb;
                    else if (s1_b_nan[i])           lane = la;
                    else if (zz)                    lane = (sb && !sa) ? lb : la;
                    else                            lane = (lt || eq) ? la : lb;
                end
                OP_MAX: begin
                    if (s1_a_nan[i] && s1_b_nan[i]) lane = CANON_NAN;
                    else if (s1_a_nan[i])           lane = lb;
                    else if (s1_b_nan[i])           lane = la;
                    else if (zz)                    lane = (sa && !sb) ? lb : la;
                    else                            lane = !lt ? la : lb;
                end
                default: lane = '0;
            endcase
            nxt_result[i*W +: W] = lane;
            nxt_nan              = nxt_nan | nan_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_op         <= OP_LT;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_a_nan      <= '0;
            s1_b_nan      <= '0;
            s1_a_zero     <= '0;
            s1_b_zero     <= '0;
            s1_mag_lt     <= '0;
            s1_mag_eq     <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            flag_nv       <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid <= bus.in_valid;
                // Operands and opcode are captured only on accept.
                if (bus.in_valid) begin
                    s1_op     <= op_e'(bus.opcode);
                    s1_a      <= bus.a;
                    s1_b      <= bus.b;
                    s1_a_nan  <= d_a_nan;
                    s1_b_nan  <= d_b_nan;
                    s1_a_zero <= d_a_zero;
                    s1_b_zero <= d_b_zero;
                    s1_mag_lt <= d_mag_lt;
                    s1_mag_eq <= d_mag_eq;
                end
                bus.out_valid <= s1_valid;
                if (s1_valid)
                    bus.result <= nxt_result;
            end
            if (adv && s1_valid && nxt_nan)
                flag_nv <= 1'b1;
            else if (flag_clr)
                flag_nv <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed and randomized checks of fp_compare_pipe
// with a 1-lane and a 4-lane instance (DLFloat16, 1-6-9) sharing clock/reset.
module tb_fp_compare_pipe;
    localparam logic [2:0] LT = 3'd0, GT = 3'd1, EQ = 3'd2, LE = 3'd3,
                           GE = 3'd4, NE = 3'd5, MIN = 3'd6, MAX = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flag_nv1, flag_clr1, flag_nv4, flag_clr4;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [15:0] exp1_q[$];
    logic [63:0] exp4_q[$];
    logic        exp4_nan_q[$];

    fp_compare_pipe_if #(.LANES(1), .W(16)) if1 ();
    fp_compare_pipe_if #(.LANES(4), .W(16)) if4 ();

    fp_compare_pipe #(.EXP_W(6), .MAN_W(9), .LANES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .flag_nv(flag_nv1), .flag_clr(flag_clr1));
    fp_compare_pipe #(.EXP_W(6), .MAN_W(9), .LANES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .flag_nv(flag_nv4), .flag_clr(flag_clr4));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit is_nan(logic [15:0] x);
        return x[14:9] == 6'h3F && x[8:0] == 9'h1FF;
    endfunction

    // Numeric value of a DLFloat16 code: (1 + m/512) * 2^(e-31), zero when e=m=0.
    function automatic real fp_val(logic [15:0] x);
        real v;
        if (x[14:0] == 15'd0) return 0.0;
        v = 1.0 + real'(x[8:0]) / 512.0;
        for (int k = 0; k < int'(x[14:9]); k++) v = v * 2.0;
        v = v / 2147483648.0;
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] model_lane(logic [2:0] op, logic [15:0] x, logic [15:0] y);
        real xv, yv;
        bit  t;
        xv = fp_val(x);
        yv = fp_val(y);
        if (op <= NE) begin
            if (is_nan(x) || is_nan(y)) return (op == NE) ? 16'hFFFF : 16'h0000;
            case (op)
                LT:      t = xv < yv;
                GT:      t = xv > yv;
                EQ:      t = xv == yv;
                LE:      t = xv <= yv;
                GE:      t = xv >= yv;
                default: t = xv != yv;
            endcase
            return t ? 16'hFFFF : 16'h0000;
        end
        if (is_nan(x) && is_nan(y)) return 16'h7FFF;
        if (is_nan(x)) return y;
        if (is_nan(y)) return x;
        if (xv == 0.0 && yv == 0.0) begin
            // Signed zeros: MIN prefers the negative zero, MAX the positive one.
            if (op == MIN) return (y[15] && !x[15]) ? y : x;
            return (x[15] && !y[15]) ? y : x;
        end
        if (op == MIN) return (yv < xv) ? y : x;
        return (yv > xv) ? y : x;
    endfunction

    function automatic logic [15:0] pick(logic [15:0] other);
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h8000;
            4:       return other;
            5:       return other ^ 16'h8000;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_one(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] res, output int lat, output logic flag);
        @(negedge clk);
        if1.in_valid  = 1'b1;
        if1.opcode    = op;
        if1.a         = x;
        if1.b         = y;
        if1.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            if1.in_valid = 1'b0;
            lat++;
        end while (!if1.out_valid && lat < 10);
        res  = if1.result;
        flag = flag_nv1;
    endtask

    task automatic drain1();
        @(negedge clk);
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        tests_run++;
        if (if1.out_valid !== 1'b0 || if1.result !== 16'h0 || flag_nv1 !== 1'b0 || if1.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_1lane: out_valid=%b result=%h flag=%b in_ready=%b, need 0 0000 0 1",
                     if1.out_valid, if1.result, flag_nv1, if1.in_ready);
        end
        tests_run++;
        if (if4.out_valid !== 1'b0 || if4.result !== 64'h0 || flag_nv4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_4lane: out_valid=%b result=%h flag=%b, need 0 0 0",
                     if4.out_valid, if4.result, flag_nv4);
        end
    endtask

    task automatic test_basic();
        logic [15:0] r;
        int          lat;
        logic        f;
        run_one(LT, 16'h3E00, 16'h4000, r, lat, f);
        tests_run++;
        if (r !== 16'hFFFF || lat !== 2) begin
            tests_failed++;
            $display("FAIL basic_lt: result=%h latency=%0d, need FFFF latency 2", r, lat);
        end
        run_one(GT, 16'h3E00, 16'h4000, r, lat, f);
        tests_run++;
        if (r !== 16'h0000 || lat !== 2) begin
            tests_failed++;
            $display("FAIL basic_gt: result=%h latency=%0d, need 0000 latency 2", r, lat);
        end
    endtask

    task automatic test_signed_zero();
        logic [2:0]  ops[4]  = '{EQ, NE, MIN, MAX};
        logic [15:0] exps[4] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
        logic [15:0] r;
        int          lat;
        logic        f;
        for (int sw = 0; sw < 2; sw++) begin
            for (int k = 0; k < 4; k++) begin
                if (sw == 0) run_one(ops[k], 16'h0000, 16'h8000, r, lat, f);
                else         run_one(ops[k], 16'h8000, 16'h0000, r, lat, f);
                tests_run++;
                if (r !== exps[k]) begin
                    tests_failed++;
                    $display("FAIL signed_zero op=%0d swap=%0d: result=%h, need %h", ops[k], sw, r, exps[k]);
                end
            end
        end
    endtask

    task automatic test_nan();
        logic [2:0]  ops[4]  = '{LT, NE, MAX, MIN};
        logic [15:0] bs[4]   = '{16'hBE00, 16'hBE00, 16'hBE00, 16'h7FFF};
        logic [15:0] exps[4] = '{16'h0000, 16'hFFFF, 16'hBE00, 16'h7FFF};
        logic [15:0] r;
        int          lat;
        logic        f;
        for (int k = 0; k < 4; k++) begin
            run_one(ops[k], 16'h7FFF, bs[k], r, lat, f);
            tests_run++;
            if (r !== exps[k] || f !== 1'b1) begin
                tests_failed++;
                $display("FAIL nan op=%0d: result=%h flag=%b, need %h flag 1", ops[k], r, f, exps[k]);
            end
        end
        // Single-cycle clear.
        @(negedge clk);
        flag_clr1 = 1'b1;
        @(negedge clk);
        flag_clr1 = 1'b0;
        tests_run++;
        if (flag_nv1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL nan_clear: flag=%b, need 0", flag_nv1);
        end
        // Clear coinciding with a NaN op entering the output stage: set wins.
        if1.in_valid = 1'b1;
        if1.opcode   = LT;
        if1.a        = 16'h7FFF;
        if1.b        = 16'h3E00;
        @(negedge clk);
        if1.in_valid = 1'b0;
        flag_clr1    = 1'b1;
        @(negedge clk);
        flag_clr1 = 1'b0;
        tests_run++;
        if (if1.out_valid !== 1'b1 || if1.result !== 16'h0000 || flag_nv1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL nan_set_wins: out_valid=%b result=%h flag=%b, need 1 0000 1",
                     if1.out_valid, if1.result, flag_nv1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs[4] = '{16'h3E00, 16'hC000, 16'h4200, 16'hBE00};
        logic [15:0] ys[4] = '{16'h4000, 16'h3E00, 16'h4100, 16'hC000};
        int          idx = 0;
        int          delivered = 0;
        logic [15:0] e;
        drain1();
        exp1_q.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (idx < 4) begin
                if1.in_valid = 1'b1;
                if1.opcode   = MAX;
                if1.a        = xs[idx];
                if1.b        = ys[idx];
            end else begin
                if1.in_valid = 1'b0;
                if1.opcode   = 3'($urandom_range(0, 7));
            end
            if1.out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                tests_run++;
                if (if1.in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_in_ready cyc=%0d: in_ready=%b, need 0", cyc, if1.in_ready);
                end
            end
            if (if1.out_valid) begin
                tests_run++;
                if (exp1_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_extra cyc=%0d: result=%h with nothing outstanding", cyc, if1.result);
                end else if (if1.out_ready) begin
                    e = exp1_q.pop_front();
                    delivered++;
                    if (if1.result !== e) begin
                        tests_failed++;
                        $display("FAIL bp_order cyc=%0d: result=%h, need %h", cyc, if1.result, e);
                    end
                end else if (if1.result !== exp1_q[0]) begin
                    tests_failed++;
                    $display("FAIL bp_hold cyc=%0d: result=%h, need %h", cyc, if1.result, exp1_q[0]);
                end
            end
            if (if1.in_valid && if1.in_ready) begin
                exp1_q.push_back(model_lane(MAX, xs[idx], ys[idx]));
                idx++;
            end
        end
        tests_run++;
        if (delivered !== 4 || exp1_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_count: delivered=%0d outstanding=%0d, need 4 and 0", delivered, exp1_q.size());
        end
    endtask

    task automatic test_lanes4();
        @(negedge clk);
        if4.in_valid  = 1'b1;
        if4.opcode    = GE;
        if4.a         = {16'h0000, 16'h7FFF, 16'hBE00, 16'h3E00};
        if4.b         = {16'h8000, 16'h3E00, 16'hC000, 16'h4000};
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if4.out_valid !== 1'b1 || if4.result !== 64'hFFFF_0000_FFFF_0000 || flag_nv4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lanes4_ge: out_valid=%b result=%h flag=%b, need 1 FFFF0000FFFF0000 1",
                     if4.out_valid, if4.result, flag_nv4);
        end
    endtask

    task automatic test_random();
        logic [63:0] xa, xb, e;
        logic        xnan, model_flag, en;
        bit          pending = 0;
        int          accepted = 0;
        @(negedge clk);
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        flag_clr4     = 1'b1;
        repeat (3) @(negedge clk);
        flag_clr4  = 1'b0;
        model_flag = 1'b0;
        exp4_q.delete();
        exp4_nan_q.delete();
        xa = '0;
        xb = '0;
        xnan = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!pending && cyc < 300 && $urandom_range(0, 3) != 0) begin
                for (int l = 0; l < 4; l++) begin
                    xb[l*16 +: 16] = pick(16'($urandom_range(0, 65535)));
                    xa[l*16 +: 16] = pick(xb[l*16 +: 16]);
                end
                if4.opcode   = 3'($urandom_range(0, 7));
                if4.a        = xa;
                if4.b        = xb;
                if4.in_valid = 1'b1;
                pending      = 1;
            end else if (!pending) begin
                if4.in_valid = 1'b0;
                if4.opcode   = 3'($urandom_range(0, 7));
            end
            if4.out_ready = (cyc >= 300) || ($urandom_range(0, 3) != 0);
            #1;
            if (if4.out_valid && if4.out_ready) begin
                tests_run++;
                if (exp4_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra cyc=%0d: result=%h with nothing outstanding", cyc, if4.result);
                end else begin
                    e  = exp4_q.pop_front();
                    en = exp4_nan_q.pop_front();
                    model_flag = model_flag | en;
                    if (if4.result !== e || flag_nv4 !== model_flag) begin
                        tests_failed++;
                        $display("FAIL rand_result cyc=%0d: result=%h flag=%b, need %h flag %b",
                                 cyc, if4.result, flag_nv4, e, model_flag);
                    end
                end
            end
            if (if4.in_valid && if4.in_ready) begin
                e    = '0;
                xnan = 1'b0;
                for (int l = 0; l < 4; l++) begin
                    e[l*16 +: 16] = model_lane(if4.opcode, xa[l*16 +: 16], xb[l*16 +: 16]);
                    xnan = xnan | is_nan(xa[l*16 +: 16]) | is_nan(xb[l*16 +: 16]);
                end
                exp4_q.push_back(e);
                exp4_nan_q.push_back(xnan);
                pending = 0;
                accepted++;
            end
        end
        tests_run++;
        if (exp4_q.size() != 0 || accepted < 100) begin
            tests_failed++;
            $display("FAIL rand_drain: outstanding=%0d accepted=%0d, need 0 and >=100",
                     exp4_q.size(), accepted);
        end
    endtask

    task automatic test_reset_mid();
        drain1();
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.opcode    = MAX;
        if1.a         = 16'h7FFF;
        if1.b         = 16'hBE00;
        @(negedge clk);
        if1.opcode = MIN;
        if1.a      = 16'h4000;
        if1.b      = 16'h3E00;
        @(negedge clk);
        if1.in_valid = 1'b0;
        tests_run++;
        if (if1.out_valid !== 1'b1 || if1.result !== 16'hBE00 || flag_nv1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: out_valid=%b result=%h flag=%b, need 1 BE00 1",
                     if1.out_valid, if1.result, flag_nv1);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (if1.out_valid !== 1'b0 || if1.result !== 16'h0000 || flag_nv1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: out_valid=%b result=%h flag=%b, need 0 0000 0",
                     if1.out_valid, if1.result, flag_nv1);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (if1.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_stale cyc=%0d: out_valid=%b result=%h, need 0", k, if1.out_valid, if1.result);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        if1.in_valid  = 1'b0;
        if1.opcode    = 3'd0;
        if1.a         = '0;
        if1.b         = '0;
        if1.out_ready = 1'b1;
        if4.in_valid  = 1'b0;
        if4.opcode    = 3'd0;
        if4.a         = '0;
        if4.b         = '0;
        if4.out_ready = 1'b1;
        flag_clr1     = 1'b0;
        flag_clr4     = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_signed_zero();
        test_nan();
        test_back_to_back();
        test_lanes4();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, multi-lane floating-point compare/min/max unit for the DLFloat-format FPU (default 1-6-9 DLFloat16).
- Extends the single-lane registered compare with six relational modes plus MIN/MAX, NaN and signed-zero handling, and a sticky invalid flag.
- Adds a 2-stage valid/ready pipeline and lane vectorisation so it sits directly on the FPU issue/writeback path.

Parameters:
EXP_W, 6, exponent field width
MAN_W, 9, mantissa field width; W = 1+EXP_W+MAN_W
LANES, 1, independent lanes processed in parallel under one opcode

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode presented
in_ready  out  1  unit accepts this cycle
opcode  in  3  000 LT, 001 GT, 010 EQ, 011 LE, 100 GE, 101 NE, 110 MIN, 111 MAX
a  in  LANES*W  operand A, lane i at [i*W +: W]
b  in  LANES*W  operand B, same packing
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
result  out  LANES*W  per-lane result
flag_nv  out  1  sticky invalid flag (NaN operand seen)
flag_clr  in  1  synchronous clear of flag_nv

Behaviour:
- Reset: clk and rst_n as named above; reset is one clock, asynchronous, active-low. Asserting rst_n low immediately clears stage-1 valid, out_valid, result (all zeros) and flag_nv. In-flight operations are dropped, not completed.
- Encoding: sign = MSB, then exponent, then mantissa.
  - NaN: exponent all ones AND mantissa all ones. Canonical NaN is 0 followed by all ones (0x7FFF for the default format).
  - Zero: exponent and mantissa both 0.
  - No subnormals.
- Ordering:
  - +0 == -0.
  - Differing signs: the negative operand is smaller, except the ±0 pair.
  - Same sign: compare {exp,man} as unsigned; the result is reversed when both are negative.
- NaN rules:
  - If either operand is NaN, LT/GT/EQ/LE/GE return false and NE returns true.
  - MIN/MAX return the non-NaN operand; if both are NaN, they return canonical NaN.
- Result per lane:
  - Relational ops: all-ones W bits if true, else all zeros.
  - MIN/MAX: the selected operand, bit-exact.
  - MIN(+0,-0) = -0 and MAX(+0,-0) = +0, in either operand order.
  - Equal non-zero values return operand a.
- Pipeline:
  - Stage 1 registers lane decode: NaN/zero flags, magnitude lt/eq, and the opcode.
  - Stage 2 registers the final result into result/out_valid.
  - Global advance: adv = !out_valid || out_ready, and in_ready = adv (combinational).
  - An input is accepted on in_valid && in_ready.
  - Latency is 2 cycles from accept to out_valid, giving a throughput of 1 per cycle while out_ready=1.
  - When adv=0, all stages hold, including bubbles; result stays stable while out_valid && !out_ready.
  - Stage-1 valid loads in_valid && adv; out_valid loads stage-1 valid when adv.
- flag_nv:
  - Set on the cycle a result enters stage 2 (adv && stage-1 valid) if any lane of that op had a NaN operand.
  - flag_clr clears it. When set and clear coincide, set wins.
  - Not cleared by pipeline flow.
- opcode is sampled only on accept. Changes while not accepted have no effect.

Test Plan:
- Reset, then a=0x3E00 (1.0), b=0x4000 (2.0), opcode LT, in_valid=1, out_ready=1 at cycle 0 -> out_valid=1 at cycle 2 with result=0xFFFF. Same operands with GT -> 0x0000.
- Signed zero: a=0x0000, b=0x8000 -> EQ gives 0xFFFF, NE gives 0x0000, MIN gives 0x8000, MAX gives 0x0000; repeat with a/b swapped and expect identical results.
- NaN: a=0x7FFF, b=0xBE00 -> LT=0x0000, NE=0xFFFF, MAX=0xBE00, and flag_nv=1 from the next cycle. a=b=0x7FFF with MIN gives 0x7FFF. flag_clr=1 for one cycle gives flag_nv=0. flag_clr asserted on the same cycle as a NaN op reaching stage 2 leaves flag_nv=1.
- Backpressure: stream 4 ops back-to-back and hold out_ready=0 from cycle 3 for 3 cycles -> in_ready=0 during the hold, result constant, and all 4 results delivered in order with none dropped or duplicated.
- LANES=4: lanes {1.0,-1.0,NaN,+0} vs {2.0,-2.0,1.0,-0}, opcode GE -> lanes {0x0000,0xFFFF,0x0000,0xFFFF}; flag_nv=1.
- Reset mid-stream: rst_n low with 2 ops in flight -> out_valid=0, result=0, and flag_nv=0 immediately. No stale result appears after release.
